imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Upstream stage to the processor's instruction memory and program counter.
- Receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit instructions.
- Writes each instruction into instruction memory and holds the core while loading.
- On completion, releases the core and pulses a PC overwrite to the load base address.

Parameters:
- ADDR_WIDTH, 8, log2 of instruction memory depth in words; max program = 2^ADDR_WIDTH words.
- BASE_ADDR, 32'h00000000, byte address of the first instruction written; also the PC restart value.
- TIMEOUT_CYCLES, 65535, max idle cycles between accepted bytes before abort.

Ports:
- clk  in  1  processor clock (divided clock domain).
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle pulse; begins a load.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  32  byte address of the write.
- imem_wdata  out  32  assembled instruction.
- cpu_hold  out  1  stalls the PC and register/data-memory writes while high.
- pc_load  out  1  one-cycle pulse; PC takes pc_value.
- pc_value  out  32  always BASE_ADDR.
- load_done  out  1  level; last load completed.
- load_error  out  1  level; last load aborted.
- words_loaded  out  16  words written in the current or last load.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0 except pc_value=BASE_ADDR. Counters, length and shift register cleared. A reset mid-load abandons it; no further writes.
- A byte is accepted on a rising clk when rx_valid && rx_ready. rx_ready is combinational from state: 1 only in LEN and DATA.
- IDLE / DONE / ERROR:
  - start -> LEN, cpu_hold=1.
  - load_done, load_error, words_loaded and byte/word counters cleared on that edge.
- LEN:
  - Accept 2 bytes as N, little-endian (first byte = N[7:0]).
  - After the 2nd byte: N==0 -> DONE; N > 2^ADDR_WIDTH -> ERROR; else -> DATA.
- DATA:
  - Accept 4 bytes into the word, first byte = bits [7:0].
  - After the 4th byte -> WRITE.
- WRITE (exactly 1 cycle):
  - imem_we=1, imem_addr=BASE_ADDR + 4*words_loaded, imem_wdata=assembled word, rx_ready=0.
  - Next edge: words_loaded+1. If the new count == N -> DONE, else -> DATA.
  - Address arithmetic is 32-bit, wrap ignored.
- DONE entry:
  - cpu_hold=0, load_done=1, pc_load=1 for exactly the entry cycle.
  - pc_load and start in the same cycle: pc_load still pulses, then LEN.
- ERROR:
  - load_error=1, cpu_hold stays 1 (core frozen), no pc_load.
  - imem contents written so far are kept.
- Timeout:
  - Idle counter runs in LEN and DATA, cleared on each accepted byte and on entering LEN.
  - Reaching TIMEOUT_CYCLES -> ERROR.
  - Counter frozen in WRITE.
- start is ignored in LEN, DATA and WRITE.
- rx_valid while rx_ready=0: byte not consumed; the sender must hold it.
- imem_we asserts only in WRITE; never two consecutive cycles.
- Throughput: 5 cycles per word minimum (4 bytes + 1 write).
- Latency: last byte accepted to pc_load = 2 cycles (WRITE, then DONE entry).

Test Plan:
- reset, start, stream 02 00 | 13 00 00 00 | 93 00 10 00 with rx_valid held -> writes 0x00000013 @0x0 and 0x00100093 @0x4, each imem_we exactly 1 cycle. pc_load pulses with pc_value 0. load_done=1, words_loaded=2, cpu_hold falls in the same cycle as pc_load.
- start, bytes 00 00 -> DONE with no imem_we, load_done=1, pc_load pulse, words_loaded=0.
- ADDR_WIDTH=8, length bytes 01 01 (N=257) -> ERROR after 2nd byte, load_error=1, cpu_hold=1, no writes, no pc_load.
- TIMEOUT_CYCLES=16: start, N=1, send 2 data bytes, then drop rx_valid -> ERROR exactly 16 cycles after the 2nd byte. A subsequent start clears load_error and accepts a fresh load.
- Random rx_valid gaps (<TIMEOUT) during a 3-word load, plus start pulses mid-load -> identical memory image to the gap-free load, start ignored, no extra writes.
- Assert reset in the middle of word 2 -> all outputs 0 immediately (asynchronous), no further imem_we. A new start plus a full stream loads correctly from BASE_ADDR.

Source files
------------

// File: rtl/imem_program_loader_if.sv
// Byte-stream valid/ready channel feeding the instruction-memory program loader.
// The sender uses the master modport, the loader uses the slave modport.
interface imem_program_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/imem_program_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory.
// It holds the core during the load, then releases it with a PC restart pulse.
module imem_program_loader #(
  parameter int          ADDR_WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  imem_program_loader_if.slave  rx,
  output logic                  imem_we,
  output logic [31:0]           imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  pc_load,
  output logic [31:0]           pc_value,
  output logic                  load_done,
  output logic                  load_error,
  output logic [15:0]           words_loaded
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  // One past the last word index: a program may fill memory exactly.
  localparam logic [16:0] MAX_WORDS    = 17'(64'd1 << ADDR_WIDTH);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state_reg;
  logic [15:0] len_reg;
  logic [1:0]  byte_cnt_reg;
  logic [31:0] word_reg;
  logic [15:0] words_reg;
  logic [31:0] idle_reg;
  logic        done_reg;
  logic        error_reg;
  logic        pc_load_reg;

  logic        ready;
  logic        accept;
  logic        timeout_hit;
  logic [15:0] len_full;
  logic [15:0] words_inc;

  assign ready       = (state_reg == S_LEN) || (state_reg == S_DATA);
  assign accept      = rx.rx_valid && ready;
  assign timeout_hit = (idle_reg == TIMEOUT_LAST);
  assign len_full    = {rx.rx_data, len_reg[7:0]};
  assign words_inc   = words_reg + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      len_reg      <= '0;
      byte_cnt_reg <= '0;
      word_reg     <= '0;
      words_reg    <= '0;
      idle_reg     <= '0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
      pc_load_reg  <= 1'b0;
    end else begin
      pc_load_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_reg    <= S_LEN;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            words_reg    <= '0;
            byte_cnt_reg <= '0;
            idle_reg     <= '0;
          end
        end
        S_LEN: begin
          if (accept) begin
            idle_reg <= '0;
            if (byte_cnt_reg == 2'd0) begin
              len_reg[7:0] <= rx.rx_data;
              byte_cnt_reg <= 2'd1;
            end else begin
              len_reg      <= len_full;
              byte_cnt_reg <= 2'd0;
              if (len_full == 16'd0) begin
                state_reg   <= S_DONE;
                done_reg    <= 1'b1;
                pc_load_reg <= 1'b1;
              end else if ({1'b0, len_full} > MAX_WORDS) begin
                state_reg <= S_ERROR;
                error_reg <= 1'b1;
              end else begin
                state_reg <= S_DATA;
              end
            end
          end else if (timeout_hit) begin
            state_reg <= S_ERROR;
            error_reg <= 1'b1;
          end else begin
            idle_reg <= idle_reg + 32'd1;
          end
        end
        S_DATA: begin
          if (accept) begin
            idle_reg     <= '0;
            // Shift right so the first byte of the word lands in bits [7:0].
            word_reg     <= {rx.rx_data, word_reg[31:8]};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              state_reg <= S_WRITE;
            end
          end else if (timeout_hit) begin
            state_reg <= S_ERROR;
            error_reg <= 1'b1;
          end else begin
            idle_reg <= idle_reg + 32'd1;
          end
        end
        S_WRITE: begin
          words_reg <= words_inc;
          if (words_inc == len_reg) begin
            state_reg   <= S_DONE;
            done_reg    <= 1'b1;
            pc_load_reg <= 1'b1;
          end else begin
            state_reg <= S_DATA;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign rx.rx_ready   = ready;
  assign imem_we       = (state_reg == S_WRITE);
  assign imem_addr     = imem_we ? (BASE_ADDR + {14'd0, words_reg, 2'b00}) : 32'd0;
  assign imem_wdata    = imem_we ? word_reg : 32'd0;
  // The core stays frozen after an aborted load; only a clean finish releases it.
  assign cpu_hold      = (state_reg == S_LEN) || (state_reg == S_DATA) ||
                         (state_reg == S_WRITE) || (state_reg == S_ERROR);
  assign pc_load       = pc_load_reg;
  assign pc_value      = BASE_ADDR;
  assign load_done     = done_reg;
  assign load_error    = error_reg;
  assign words_loaded  = words_reg;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed and randomized checks of the program loader against a word-level model:
// expected writes are BASE + 4*i with the i-th program word, bytes sent little-endian.
module tb_imem_program_loader;
  localparam int          AW   = 8;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          TMO  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        pc_load;
  logic [31:0] pc_value;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;

  imem_program_loader_if rx ();

  imem_program_loader #(
    .ADDR_WIDTH     (AW),
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx           (rx),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .pc_load      (pc_load),
    .pc_value     (pc_value),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed write and PC-restart events, sampled mid-cycle.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          consec_we   = 0;
  int          pc_load_cnt = 0;
  int          pc_load_cyc = 0;
  logic        hold_before_pc = 1'b0;
  logic        prev_we   = 1'b0;
  logic        prev_hold = 1'b0;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      $display("write addr=%h data=%h words_loaded=%0d", imem_addr, imem_wdata, words_loaded);
      if (prev_we) consec_we++;
    end
    if (pc_load === 1'b1) begin
      pc_load_cnt++;
      pc_load_cyc    = cyc;
      hold_before_pc = prev_hold;
    end
    prev_we   = (imem_we === 1'b1);
    prev_hold = (cpu_hold === 1'b1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int last_acc_cyc = 0;

  // Present one byte after an optional valid-low gap; start may pulse in the gap.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_st);
    int  n;
    bit  acc;
    if (gap > 0) begin
      rx.rx_valid = 1'b0;
      for (int i = 0; i < gap; i++) begin
        start = pulse_st && (i == 0);
        @(posedge clk); #1;
      end
      start = 1'b0;
    end
    rx.rx_valid = 1'b1;
    rx.rx_data  = b;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = (rx.rx_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("byte_accept_bound", 32'd0, 32'd1);
    last_acc_cyc = cyc;
  endtask

  function automatic int pick_gap(input int max_gap);
    return (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
  endfunction

  function automatic bit pick_start(input bit with_starts);
    return with_starts && ($urandom_range(0, 2) == 0);
  endfunction

  logic [31:0] model_words[$];

  task automatic send_program(input int max_gap, input bit with_starts);
    logic [15:0] n;
    logic [31:0] w;
    n = 16'(model_words.size());
    send_byte(n[7:0],  pick_gap(max_gap), pick_start(with_starts));
    send_byte(n[15:8], pick_gap(max_gap), pick_start(with_starts));
    foreach (model_words[i]) begin
      w = model_words[i];
      for (int k = 0; k < 4; k++)
        send_byte(w[8*k +: 8], pick_gap(max_gap), pick_start(with_starts));
    end
    rx.rx_valid = 1'b0;
  endtask

  task automatic random_words(input int n);
    model_words.delete();
    for (int i = 0; i < n; i++) model_words.push_back($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    rx.rx_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Leaves the bench mid-cycle in the pc_load cycle.
  task automatic wait_pc_load(input int base_cnt);
    int n;
    n = 0;
    while (pc_load_cnt == base_cnt && n < 64) begin
      @(negedge clk); #1;
      n++;
    end
    chk("pc_load_pulses", 32'(pc_load_cnt - base_cnt), 32'd1);
  endtask

  task automatic check_image(input string tag, input int base);
    chk({tag, "_nwrites"}, 32'(wr_addr_q.size() - base), 32'(model_words.size()));
    for (int i = 0; i < model_words.size(); i++) begin
      if (base + i < wr_addr_q.size()) begin
        chk({tag, "_addr"}, wr_addr_q[base + i], BASE + 32'(4 * i));
        chk({tag, "_data"}, wr_data_q[base + i], model_words[i]);
      end
    end
  endtask

  int wbase;
  int pbase;
  int n_wait;
  int err_cyc;

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    rx.rx_valid = 1'b0;
    rx.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_rx_ready",   32'(rx.rx_ready), 32'd0);
    chk("rst_imem_we",    32'(imem_we), 32'd0);
    chk("rst_imem_addr",  imem_addr, 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_hold",   32'(cpu_hold), 32'd0);
    chk("rst_pc_load",    32'(pc_load), 32'd0);
    chk("rst_pc_value",   pc_value, BASE);
    chk("rst_load_done",  32'(load_done), 32'd0);
    chk("rst_load_error", 32'(load_error), 32'd0);
    chk("rst_words",      32'(words_loaded), 32'd0);

    // Two-word program with rx_valid held: 02 00 | 13 00 00 00 | 93 00 10 00
    pulse_start();
    chk("t1_hold_in_len",  32'(cpu_hold), 32'd1);
    chk("t1_ready_in_len", 32'(rx.rx_ready), 32'd1);
    wbase = wr_addr_q.size();
    pbase = pc_load_cnt;
    model_words.delete();
    model_words.push_back(32'h0000_0013);
    model_words.push_back(32'h0010_0093);
    send_program(0, 1'b0);
    wait_pc_load(pbase);
    // WRITE fills the cycle after the last byte's edge, pc_load the one after that.
    chk("t1_pc_load_latency", 32'(pc_load_cyc - last_acc_cyc), 32'd1);
    chk("t1_pc_value",     pc_value, 32'h0000_0000);
    chk("t1_hold_at_pc",   32'(cpu_hold), 32'd0);
    chk("t1_hold_before",  32'(hold_before_pc), 32'd1);
    chk("t1_load_done",    32'(load_done), 32'd1);
    chk("t1_words_loaded", 32'(words_loaded), 32'd2);
    check_image("t1", wbase);
    chk("t1_consec_we",    32'(consec_we), 32'd0);
    @(negedge clk); #1;
    chk("t1_pc_load_one_cycle", 32'(pc_load), 32'd0);

    // Zero-length program
    pulse_start();
    chk("t2_done_cleared", 32'(load_done), 32'd0);
    wbase = wr_addr_q.size();
    pbase = pc_load_cnt;
    model_words.delete();
    send_program(0, 1'b0);
    wait_pc_load(pbase);
    chk("t2_nwrites",     32'(wr_addr_q.size() - wbase), 32'd0);
    chk("t2_load_done",   32'(load_done), 32'd1);
    chk("t2_words",       32'(words_loaded), 32'd0);
    chk("t2_hold",        32'(cpu_hold), 32'd0);

    // Oversized length 257: start lands in the pc_load cycle and must still be taken
    pulse_start();
    chk("t3_start_on_pc_load", 32'(rx.rx_ready), 32'd1);
    wbase = wr_addr_q.size();
    pbase = pc_load_cnt;
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    idle_cycles(3);
    chk("t3_load_error", 32'(load_error), 32'd1);
    chk("t3_load_done",  32'(load_done), 32'd0);
    chk("t3_hold",       32'(cpu_hold), 32'd1);
    chk("t3_rx_ready",   32'(rx.rx_ready), 32'd0);
    chk("t3_nwrites",    32'(wr_addr_q.size() - wbase), 32'd0);
    chk("t3_no_pc_load", 32'(pc_load_cnt - pbase), 32'd0);

    // Timeout: N=1, two data bytes, then silence
    pulse_start();
    chk("t4_error_cleared", 32'(load_error), 32'd0);
    wbase = wr_addr_q.size();
    pbase = pc_load_cnt;
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'($urandom), 0, 1'b0);
    send_byte(8'($urandom), 0, 1'b0);
    rx.rx_valid = 1'b0;
    n_wait = 0;
    while (load_error !== 1'b1 && n_wait < 64) begin
      @(negedge clk);
      n_wait++;
    end
    err_cyc = cyc;
    chk("t4_timeout_edges", 32'(err_cyc - last_acc_cyc), 32'(TMO));
    chk("t4_hold",       32'(cpu_hold), 32'd1);
    chk("t4_nwrites",    32'(wr_addr_q.size() - wbase), 32'd0);
    chk("t4_no_pc_load", 32'(pc_load_cnt - pbase), 32'd0);
    #1;
    pulse_start();
    chk("t4_restart_clears_error", 32'(load_error), 32'd0);
    wbase = wr_addr_q.size();
    pbase = pc_load_cnt;
    random_words(1);
    send_program(0, 1'b0);
    wait_pc_load(pbase);
    check_image("t4_fresh", wbase);
    chk("t4_fresh_done", 32'(load_done), 32'd1);

    // Three-word loads: gap-free, then with random gaps and stray start pulses
    random_words(3);
    for (int pass = 0; pass < 3; pass++) begin
      @(negedge clk); #1;
      pulse_start();
      wbase = wr_addr_q.size();
      pbase = pc_load_cnt;
      send_program((pass == 0) ? 0 : 12, pass != 0);
      wait_pc_load(pbase);
      check_image((pass == 0) ? "t5_nogap" : "t5_gaps", wbase);
      chk("t5_words",      32'(words_loaded), 32'd3);
      chk("t5_done",       32'(load_done), 32'd1);
      chk("t5_consec_we",  32'(consec_we), 32'd0);
    end

    // Asynchronous reset in the middle of word 2
    @(negedge clk); #1;
    pulse_start();
    random_words(3);
    send_byte(8'h03, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(model_words[0][8*k +: 8], 0, 1'b0);
    send_byte(model_words[1][7:0], 0, 1'b0);
    send_byte(model_words[1][15:8], 0, 1'b0);
    chk("t6_words_before_reset", 32'(words_loaded), 32'd1);
    #2;
    reset = 1'b1;
    wbase = wr_addr_q.size();
    #1;
    chk("t6_rst_rx_ready",  32'(rx.rx_ready), 32'd0);
    chk("t6_rst_hold",      32'(cpu_hold), 32'd0);
    chk("t6_rst_we",        32'(imem_we), 32'd0);
    chk("t6_rst_words",     32'(words_loaded), 32'd0);
    chk("t6_rst_done",      32'(load_done), 32'd0);
    chk("t6_rst_error",     32'(load_error), 32'd0);
    chk("t6_rst_pc_load",   32'(pc_load), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_cycles(8);
    chk("t6_no_writes_after_reset", 32'(wr_addr_q.size() - wbase), 32'd0);
    pulse_start();
    wbase = wr_addr_q.size();
    pbase = pc_load_cnt;
    random_words(2);
    send_program(0, 1'b0);
    wait_pc_load(pbase);
    check_image("t6_reload", wbase);
    chk("t6_reload_words", 32'(words_loaded), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
